// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the three-requester Avalon-MM master arbiter.
package avalon_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int REQ_INSTR = 0;
    localparam int REQ_EXT   = 1;
    localparam int REQ_DBG   = 2;
    localparam int NUM_REQ   = 3;

    localparam logic [NUM_REQ-1:0] GNT_NONE  = 3'b000;
    localparam logic [NUM_REQ-1:0] GNT_INSTR = 3'b001;
    localparam logic [NUM_REQ-1:0] GNT_EXT   = 3'b010;
    localparam logic [NUM_REQ-1:0] GNT_DBG   = 3'b100;

    // Stall counter width; a disabled timeout still needs one bit to declare.
    function automatic int cnt_w(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/arb_prio_rr.sv
// Combinational winner picker: debug strictly first, ext/instr alternate on last_ext.
module arb_prio_rr
    import avalon_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_last_ext,
    input  logic               i_lock,
    output logic [NUM_REQ-1:0] o_win
);

    always_comb begin
        o_win = GNT_NONE;
        if (i_req[REQ_DBG]) begin
            o_win = GNT_DBG;
        end else if (!i_lock) begin
            // With both pending, ext only wins if it was not the last one served.
            if (i_req[REQ_EXT] && (!i_req[REQ_INSTR] || !i_last_ext))
                o_win = GNT_EXT;
            else if (i_req[REQ_INSTR])
                o_win = GNT_INSTR;
        end
    end

endmodule

// File: rtl/avalon_master_arbiter.sv
// Shares one Avalon-MM master between debug, ext (data) and instr requesters,
// sequencing issue / wait-request stall / completion for the granted one.
module avalon_master_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             req_dbg,
    input  logic             req_ext,
    input  logic             req_instr,
    input  logic             rnw_dbg,
    input  logic             rnw_ext,
    input  logic             rnw_instr,
    input  logic [WIDTH-1:0] addr_dbg,
    input  logic [WIDTH-1:0] addr_ext,
    input  logic [WIDTH-1:0] addr_instr,
    input  logic [WIDTH-1:0] wdata_dbg,
    input  logic [WIDTH-1:0] wdata_ext,
    input  logic [WIDTH-1:0] wdata_instr,
    input  logic             lock_dbg,
    output logic             done_dbg,
    output logic             done_ext,
    output logic             done_instr,
    output logic [WIDTH-1:0] rdata,
    output logic             err,
    output logic [2:0]       grant,
    output logic [WIDTH-1:0] ADDRESS,
    output logic             BEGINTRANSFER,
    output logic             READ,
    output logic             WRITE,
    output logic [WIDTH-1:0] WRITEDATA,
    output logic             LOCK,
    input  logic [WIDTH-1:0] READDATA,
    input  logic             WAITREQUEST
);

    localparam int            CW      = cnt_w(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_owner;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_last_ext;
    logic [CW-1:0]      r_cnt;
    logic               r_rnw;
    logic [WIDTH-1:0]   r_addr;
    logic [WIDTH-1:0]   r_wdata;
    logic [WIDTH-1:0]   r_rdata;
    logic               r_read;
    logic               r_write;
    logic               r_begin;
    logic               r_lock;
    logic               r_err;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_win;
    logic               w_locked;
    logic               w_launch;
    logic               w_sel_rnw;
    logic [WIDTH-1:0]   w_sel_addr;
    logic [WIDTH-1:0]   w_sel_wdata;
    logic [CW-1:0]      w_cnt_inc;
    logic               w_timeout;

    assign w_req    = {req_dbg, req_ext, req_instr};
    // Debug keeps the bus across DONE only while it still holds lock.
    assign w_locked = (r_state == DONE) && r_owner[REQ_DBG] && lock_dbg;

    arb_prio_rr u_prio (
        .i_req      (w_req),
        .i_last_ext (r_last_ext),
        .i_lock     (w_locked),
        .o_win      (w_win)
    );

    assign w_launch = (r_state == IDLE) ? (|w_win)
                    : ((r_state == DONE) && w_locked && w_win[REQ_DBG]);

    always_comb begin
        w_sel_rnw   = rnw_instr;
        w_sel_addr  = addr_instr;
        w_sel_wdata = wdata_instr;
        if (w_win[REQ_DBG]) begin
            w_sel_rnw   = rnw_dbg;
            w_sel_addr  = addr_dbg;
            w_sel_wdata = wdata_dbg;
        end else if (w_win[REQ_EXT]) begin
            w_sel_rnw   = rnw_ext;
            w_sel_addr  = addr_ext;
            w_sel_wdata = wdata_ext;
        end
    end

    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == TO_VAL);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_owner    <= GNT_NONE;
            r_grant    <= GNT_NONE;
            r_done     <= GNT_NONE;
            r_last_ext <= 1'b0;
            r_cnt      <= '0;
            r_rnw      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_begin    <= 1'b0;
            r_lock     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_begin <= 1'b0;
            r_done  <= GNT_NONE;
            case (r_state)
                IDLE, DONE: begin
                    if (r_state == DONE) begin
                        r_err <= 1'b0;
                        if (!r_owner[REQ_DBG])
                            r_last_ext <= r_owner[REQ_EXT];
                    end
                    if (w_launch) begin
                        r_state <= ISSUE;
                        r_owner <= w_win;
                        r_grant <= w_win;
                        r_rnw   <= w_sel_rnw;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_read  <= w_sel_rnw;
                        r_write <= ~w_sel_rnw;
                        r_begin <= 1'b1;
                        r_lock  <= w_win[REQ_DBG] & lock_dbg;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= IDLE;
                        r_owner <= GNT_NONE;
                        r_grant <= GNT_NONE;
                        r_lock  <= 1'b0;
                    end
                end
                ISSUE, WAIT: begin
                    r_lock <= r_owner[REQ_DBG] & lock_dbg;
                    if (!WAITREQUEST || (r_state == WAIT && w_timeout)) begin
                        // A late completion on the timeout edge still wins over the abort.
                        if (!WAITREQUEST && r_rnw)
                            r_rdata <= READDATA;
                        r_err   <= WAITREQUEST;
                        r_state <= DONE;
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_done  <= r_owner;
                        r_grant <= GNT_NONE;
                    end else begin
                        r_state <= WAIT;
                        if (r_state == WAIT)
                            r_cnt <= w_cnt_inc;
                    end
                end
            endcase
        end
    end

    assign done_dbg      = r_done[REQ_DBG];
    assign done_ext      = r_done[REQ_EXT];
    assign done_instr    = r_done[REQ_INSTR];
    assign rdata         = r_rdata;
    assign err           = r_err;
    assign grant         = r_grant;
    assign ADDRESS       = r_addr;
    assign BEGINTRANSFER = r_begin;
    assign READ          = r_read;
    assign WRITE         = r_write;
    assign WRITEDATA     = r_wdata;
    assign LOCK          = r_lock;

endmodule

// File: doc/avalon_master_arbiter.md
# avalon_master_arbiter

Shares one Avalon-MM master port between three requesters: the debug unit, the core's data (ext) path and the core's instruction-fetch path. Arbitrates between them and sequences each transfer (issue, wait-request stall, completion). Returns read data and a one-cycle done pulse to the winning requester. Sits between the core/debug logic and the single system-bus master, replacing the per-path masters where only one bus port is available.

## Interface
- WIDTH, 32: address/data width.
- TIMEOUT, 1024: maximum WAITREQUEST stall cycles before abort; 0 disables the timeout.

- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- req_dbg / req_ext / req_instr  in  1 each  transfer request; level, held until the matching done.
- rnw_dbg / rnw_ext / rnw_instr  in  1 each  1 = read, 0 = write; stable while req is high.
- addr_dbg / addr_ext / addr_instr  in  WIDTH each  transfer address.
- wdata_dbg / wdata_ext / wdata_instr  in  WIDTH each  write data.
- lock_dbg  in  1  debug keeps ownership of the bus for back-to-back transfers.
- done_dbg / done_ext / done_instr  out  1 each  one-cycle completion pulse.
- rdata  out  WIDTH  registered read data; valid in the done cycle and held until the next completion.
- err  out  1  valid with done: 1 = transfer aborted by timeout.
- grant  out  3  one-hot owner: [2] = dbg, [1] = ext, [0] = instr; 0 when idle.
- ADDRESS  out  WIDTH  Avalon address.
- BEGINTRANSFER  out  1  high only in the first issue cycle.
- READ / WRITE  out  1 each  Avalon strobes.
- WRITEDATA  out  WIDTH  Avalon write data.
- LOCK  out  1  Avalon lock.
- READDATA  in  WIDTH  Avalon read data.
- WAITREQUEST  in  1  slave stall.

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - If any req is high, choose the winner, register grant and latch that requester's rnw/addr/wdata, then go to ISSUE.
  - With no request, stay in IDLE and keep grant = 0.
- **Priority:**
  - Debug is strictly highest.
  - ext and instr rotate round-robin using a last_ext flag. When both are requesting, the one not served last wins. After reset, ext wins first.
- **ISSUE (one cycle):**
  - Drive ADDRESS, WRITEDATA, and READ = rnw or WRITE = ~rnw.
  - BEGINTRANSFER = 1 in this cycle only.
  - WAITREQUEST = 0: complete. On a read, capture READDATA into rdata, then go to DONE.
  - WAITREQUEST = 1: go to WAIT.
- **WAIT:**
  - Hold all bus outputs, with BEGINTRANSFER = 0, and increment the stall counter.
  - WAITREQUEST = 0: complete as in ISSUE, then go to DONE.
  - If the counter reaches TIMEOUT (and TIMEOUT ≠ 0): drop the strobes, set err, go to DONE; rdata is unchanged.
- **DONE (one cycle):**
  - Pulse the granted requester's done, with err valid.
  - Strobes are low, grant is cleared, and last_ext is updated.
  - Go to IDLE.
- **Lock:**
  - LOCK = lock_dbg while debug owns the bus.
  - If lock_dbg and req_dbg are still high in DONE, go straight to ISSUE for debug, skipping IDLE. Other requesters cannot win in between.
- **Requester rules:**
  - A requester that drops req before its done has already been committed: the transfer completes and done still pulses.
  - A new req from that requester is sampled only in IDLE.
- **Widths:** the stall counter is $clog2(TIMEOUT+1) bits and saturates; no other arithmetic.

## Timing
- **Reset:** async assertion forces all outputs to 0, state to IDLE, last_ext = 0 and counter = 0 immediately, even mid-transfer. The aborted transfer produces no done.
- **Zero-wait transfer:** req sampled at edge 0 → ISSUE in cycle 1 → done in cycle 2. That is 3 cycles from sampling; throughput is one transfer per 3 cycles.
- **Locked debug burst:** one transfer per 2 cycles.
- **Stall of N cycles:** done arrives at cycle 2+N.
- **Simultaneous requests:** when all three arrive together, debug is served first, then ext, then instr.
- **Outside a transfer:** READ and WRITE are never both high, and strobes are never high outside ISSUE/WAIT.

## Structure
- Package avalon_arb_pkg holds:
  - the state enum arb_state_t (IDLE, ISSUE, WAIT, DONE);
  - requester index constants REQ_INSTR = 0, REQ_EXT = 1, REQ_DBG = 2;
  - the one-hot grant encoding.
- Sub-module arb_prio_rr: purely combinational picker.
  - Inputs: the 3 request lines, last_ext and lock state.
  - Output: a one-hot winner.
  - Verified standalone.

## Test plan
- req_ext read of 0x100, WAITREQUEST = 0, READDATA = 0xDEADBEEF → READ + BEGINTRANSFER in cycle 1, done_ext in cycle 2, rdata = 0xDEADBEEF, err = 0.
- req_dbg, req_ext and req_instr raised in the same cycle, all reads → grant order 100, 010, 001, each with exactly one done pulse.
- req_instr write of 0x55 to 0x20, WAITREQUEST high for 5 cycles → ADDRESS/WRITEDATA stable throughout, BEGINTRANSFER only in the first cycle, done_instr at cycle 7.
- TIMEOUT = 8, WAITREQUEST stuck high → strobes drop after 8 stall cycles, done_ext with err = 1, previous rdata retained.
- lock_dbg = 1 with 3 debug writes while req_ext is held → 3 consecutive debug transfers 2 cycles apart with LOCK = 1, ext granted only afterwards.
- RST_N asserted during WAIT → all outputs 0 asynchronously, no done. After release, a pending req_ext is served normally.
